// File: rtl/bus_fifo_slave_if.sv
// Bus-side signal bundle for one slave slot of the single-master bus.
// The master drives select/write/address/data; the slave returns read data and irq.
interface bus_fifo_slave_if;
  logic        s_sel;
  logic        s_wr;
  logic [15:0] s_addr;
  logic [63:0] s_din;
  logic [63:0] s_dout;
  logic        irq;

  modport slave  (input  s_sel, s_wr, s_addr, s_din, output s_dout, irq);
  modport master (output s_sel, s_wr, s_addr, s_din, input  s_dout, irq);
endinterface

// File: rtl/bus_fifo_slave.sv
// Memory-mapped 64-bit FIFO slave: DATA push/pop, STATUS, CTRL flush/clear, INT_EN.
// Read data is registered so it lines up with the bus's registered read-mux select.
module bus_fifo_slave #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  bus_fifo_slave_if.slave  bus
);

  localparam logic [3:0] OFF_DATA   = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h1;
  localparam logic [3:0] OFF_CTRL   = 4'h2;
  localparam logic [3:0] OFF_INTEN  = 4'h3;

  logic [63:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic [1:0]    int_en_q, int_en_d;
  logic [63:0]   s_dout_q, s_dout_d;
  logic          irq_q, irq_d;
  logic          mem_we;

  logic          wr_acc, rd_acc;
  logic          empty, full;
  logic [7:0]    count8;
  logic [63:0]   status_word;

  // Gating with s_sel first keeps X on an unselected bus from reaching any state.
  assign wr_acc = bus.s_sel & bus.s_wr;
  assign rd_acc = bus.s_sel & ~bus.s_wr;

  assign empty       = (count_q == '0);
  assign full        = (count_q == (AW+1)'(DEPTH));
  assign count8      = 8'(count_q);
  assign status_word = {48'd0, count8, 4'd0, unf_q, ovf_q, full, empty};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    int_en_d = int_en_q;
    s_dout_d = 64'd0;
    mem_we   = 1'b0;

    if (bus.s_sel) begin
      case (bus.s_addr[3:0])
        OFF_DATA: begin
          if (wr_acc) begin
            if (!full) begin
              mem_we   = 1'b1;
              wr_ptr_d = wr_ptr_q + AW'(1);
              count_d  = count_q + (AW+1)'(1);
            end else begin
              ovf_d = 1'b1;
            end
          end else if (rd_acc) begin
            if (!empty) begin
              s_dout_d = mem[rd_ptr_q];
              rd_ptr_d = rd_ptr_q + AW'(1);
              count_d  = count_q - (AW+1)'(1);
            end else begin
              unf_d = 1'b1;
            end
          end
        end
        OFF_STATUS: begin
          if (rd_acc) s_dout_d = status_word;
        end
        OFF_CTRL: begin
          if (wr_acc) begin
            if (bus.s_din[0]) begin
              wr_ptr_d = '0;
              rd_ptr_d = '0;
              count_d  = '0;
            end
            if (bus.s_din[1]) begin
              ovf_d = 1'b0;
              unf_d = 1'b0;
            end
          end
        end
        OFF_INTEN: begin
          if (wr_acc)      int_en_d = bus.s_din[1:0];
          else if (rd_acc) s_dout_d = {62'd0, int_en_q};
        end
        default: ;
      endcase
    end

    irq_d = (int_en_q[0] & (count_d != '0)) | (int_en_q[1] & (ovf_d | unf_d));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      int_en_q <= 2'b00;
      s_dout_q <= 64'd0;
      irq_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      int_en_q <= int_en_d;
      s_dout_q <= s_dout_d;
      irq_q    <= irq_d;
    end
  end

  // Storage has no reset; a push concurrent with reset is discarded.
  always_ff @(posedge clk) begin
    if (reset_n && mem_we) mem[wr_ptr_q] <= bus.s_din;
  end

  assign bus.s_dout = s_dout_q;
  assign bus.irq    = irq_q;

endmodule

// File: tb/tb_bus_fifo_slave.sv
// Directed self-checking bench for bus_fifo_slave (DEPTH=8); one line per transaction.
module tb_bus_fifo_slave;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  bus_fifo_slave_if bus ();

  bus_fifo_slave #(.DEPTH(8), .AW(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All tasks start and end 1ns after a rising edge.
  task automatic bus_idle(input int n);
    bus.s_sel  = 1'b0;
    bus.s_wr   = 1'bx;
    bus.s_addr = 'x;
    bus.s_din  = 'x;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] off, input logic [63:0] data);
    bus.s_sel  = 1'b1;
    bus.s_wr   = 1'b1;
    bus.s_addr = {12'd0, off};
    bus.s_din  = data;
    @(posedge clk);
    #1;
    bus.s_sel  = 1'b0;
    bus.s_wr   = 1'bx;
    bus.s_addr = 'x;
    bus.s_din  = 'x;
    $display("WR  off=%0h data=%016h irq=%0b", off, data, bus.irq);
  endtask

  task automatic bus_read(input logic [3:0] off, output logic [63:0] data);
    bus.s_sel  = 1'b1;
    bus.s_wr   = 1'b0;
    bus.s_addr = {12'd0, off};
    bus.s_din  = 'x;
    @(posedge clk);
    #1;
    bus.s_sel  = 1'b0;
    bus.s_wr   = 1'bx;
    bus.s_addr = 'x;
    data = bus.s_dout;
    $display("RD  off=%0h data=%016h irq=%0b", off, data, bus.irq);
  endtask

  task automatic test_reset();
    logic [63:0] d;
    reset_n = 1'b0;
    bus_idle(2);
    reset_n = 1'b1;
    checks++;
    if (bus.s_dout !== 64'd0) begin
      errors++; $display("FAIL reset_dout got=%016h exp=0", bus.s_dout);
    end
    bus_read(4'h1, d);
    checks++;
    if (d !== 64'h1) begin
      errors++; $display("FAIL reset_status got=%016h exp=%016h", d, 64'h1);
    end
    checks++;
    if (bus.irq !== 1'b0) begin
      errors++; $display("FAIL reset_irq got=%0b exp=0", bus.irq);
    end
  endtask

  task automatic test_push_pop();
    logic [63:0] d;
    bus_write(4'h0, 64'h1111_1111_1111_1111);
    bus_write(4'h0, 64'h2222_2222_2222_2222);
    bus_read(4'h1, d);
    checks++;
    if (d !== 64'h0000_0000_0000_0200) begin
      errors++; $display("FAIL pp_status2 got=%016h exp=%016h", d, 64'h200);
    end
    bus_read(4'h0, d);
    checks++;
    if (d !== 64'h1111_1111_1111_1111) begin
      errors++; $display("FAIL pp_pop1 got=%016h exp=%016h", d, 64'h1111_1111_1111_1111);
    end
    bus_read(4'h0, d);
    checks++;
    if (d !== 64'h2222_2222_2222_2222) begin
      errors++; $display("FAIL pp_pop2 got=%016h exp=%016h", d, 64'h2222_2222_2222_2222);
    end
    bus_idle(1);
    checks++;
    if (bus.s_dout !== 64'd0) begin
      errors++; $display("FAIL pp_idle_zero got=%016h exp=0", bus.s_dout);
    end
    bus_read(4'h1, d);
    checks++;
    if (d !== 64'h1) begin
      errors++; $display("FAIL pp_status0 got=%016h exp=%016h", d, 64'h1);
    end
  endtask

  task automatic test_overflow();
    logic [63:0] d;
    for (int i = 1; i <= 9; i++) bus_write(4'h0, 64'(i));
    bus_read(4'h1, d);
    checks++;
    if (d !== 64'h0806) begin
      errors++; $display("FAIL ovf_status got=%016h exp=%016h", d, 64'h0806);
    end
    for (int i = 1; i <= 8; i++) begin
      bus_read(4'h0, d);
      checks++;
      if (d !== 64'(i)) begin
        errors++; $display("FAIL ovf_pop%0d got=%016h exp=%016h", i, d, 64'(i));
      end
    end
    bus_read(4'h1, d);
    checks++;
    if (d !== 64'h5) begin
      errors++; $display("FAIL ovf_drained got=%016h exp=%016h", d, 64'h5);
    end
  endtask

  task automatic test_underflow();
    logic [63:0] d;
    bus_read(4'h0, d);
    checks++;
    if (d !== 64'd0) begin
      errors++; $display("FAIL unf_pop got=%016h exp=0", d);
    end
    bus_read(4'h1, d);
    checks++;
    if (d !== 64'hD) begin
      errors++; $display("FAIL unf_status got=%016h exp=%016h", d, 64'hD);
    end
    bus_write(4'h2, 64'h2);
    bus_read(4'h1, d);
    checks++;
    if (d !== 64'h1) begin
      errors++; $display("FAIL unf_clear got=%016h exp=%016h", d, 64'h1);
    end
  endtask

  task automatic test_irq();
    logic [63:0] d;
    bus_write(4'h3, 64'h1);
    bus_read(4'h3, d);
    checks++;
    if (d !== 64'h1) begin
      errors++; $display("FAIL irq_inten_rd got=%016h exp=1", d);
    end
    bus_write(4'h0, 64'h0000_0000_0000_00AB);
    checks++;
    if (bus.irq !== 1'b1) begin
      errors++; $display("FAIL irq_notempty got=%0b exp=1", bus.irq);
    end
    bus_read(4'h0, d);
    checks++;
    if (bus.irq !== 1'b0 || d !== 64'hAB) begin
      errors++; $display("FAIL irq_pop got irq=%0b data=%016h exp irq=0 data=ab", bus.irq, d);
    end
    bus_write(4'h3, 64'h2);
    for (int i = 0; i < 8; i++) bus_write(4'h0, 64'h40 + 64'(i));
    checks++;
    if (bus.irq !== 1'b0) begin
      errors++; $display("FAIL irq_full_no_err got=%0b exp=0", bus.irq);
    end
    bus_write(4'h0, 64'h99);
    checks++;
    if (bus.irq !== 1'b1) begin
      errors++; $display("FAIL irq_ovf got=%0b exp=1", bus.irq);
    end
    bus_idle(3);
    checks++;
    if (bus.irq !== 1'b1) begin
      errors++; $display("FAIL irq_ovf_hold got=%0b exp=1", bus.irq);
    end
    bus_write(4'h2, 64'h2);
    checks++;
    if (bus.irq !== 1'b0) begin
      errors++; $display("FAIL irq_clear got=%0b exp=0", bus.irq);
    end
    bus_read(4'h1, d);
    checks++;
    if (d !== 64'h0802) begin
      errors++; $display("FAIL irq_status got=%016h exp=%016h", d, 64'h0802);
    end
    bus_write(4'h2, 64'h1);
    bus_read(4'h1, d);
    checks++;
    if (d !== 64'h1) begin
      errors++; $display("FAIL flush_status got=%016h exp=%016h", d, 64'h1);
    end
    bus_write(4'h0, 64'h77);
    bus_read(4'h0, d);
    checks++;
    if (d !== 64'h77) begin
      errors++; $display("FAIL flush_push got=%016h exp=%016h", d, 64'h77);
    end
    bus_write(4'h3, 64'h0);
  endtask

  task automatic test_wrap();
    logic [63:0] d;
    for (int i = 0; i < 6; i++) bus_write(4'h0, 64'h100 + 64'(i));
    for (int i = 0; i < 6; i++) begin
      bus_read(4'h0, d);
      checks++;
      if (d !== 64'h100 + 64'(i)) begin
        errors++; $display("FAIL wrap_a%0d got=%016h exp=%016h", i, d, 64'h100 + 64'(i));
      end
    end
    for (int i = 0; i < 5; i++) bus_write(4'h0, 64'h200 + 64'(i));
    for (int i = 0; i < 5; i++) begin
      bus_read(4'h0, d);
      checks++;
      if (d !== 64'h200 + 64'(i)) begin
        errors++; $display("FAIL wrap_b%0d got=%016h exp=%016h", i, d, 64'h200 + 64'(i));
      end
    end
  endtask

  task automatic test_unmapped();
    logic [63:0] d;
    bus_write(4'h5, 64'hFFFF_FFFF_FFFF_FFFF);
    bus_read(4'h5, d);
    checks++;
    if (d !== 64'd0) begin
      errors++; $display("FAIL unmapped_rd got=%016h exp=0", d);
    end
    bus_read(4'h2, d);
    checks++;
    if (d !== 64'd0) begin
      errors++; $display("FAIL ctrl_rd got=%016h exp=0", d);
    end
    bus_write(4'h3, 64'hFF);
    bus_read(4'h3, d);
    checks++;
    if (d !== 64'h3) begin
      errors++; $display("FAIL inten_mask got=%016h exp=3", d);
    end
    bus_write(4'h3, 64'h0);
    bus_read(4'h1, d);
    checks++;
    if (d !== 64'h1) begin
      errors++; $display("FAIL unmapped_status got=%016h exp=1", d);
    end
  endtask

  task automatic test_unselected();
    logic [63:0] d;
    bus.s_sel  = 1'b0;
    bus.s_wr   = 1'b1;
    bus.s_addr = 16'h0000;
    bus.s_din  = 64'hDEAD_BEEF_0000_0001;
    repeat (3) @(posedge clk);
    #1;
    bus.s_addr = 16'h0002;
    bus.s_din  = 64'h3;
    repeat (2) @(posedge clk);
    #1;
    bus_read(4'h1, d);
    checks++;
    if (d !== 64'h1) begin
      errors++; $display("FAIL unsel_status got=%016h exp=1", d);
    end
  endtask

  task automatic test_mid_reset();
    logic [63:0] d;
    bus_write(4'h3, 64'h3);
    for (int i = 0; i < 3; i++) bus_write(4'h0, 64'h300 + 64'(i));
    checks++;
    if (bus.irq !== 1'b1) begin
      errors++; $display("FAIL mr_pre_irq got=%0b exp=1", bus.irq);
    end
    reset_n = 1'b0;
    bus_write(4'h0, 64'h3FF);
    reset_n = 1'b1;
    checks++;
    if (bus.irq !== 1'b0) begin
      errors++; $display("FAIL mr_irq got=%0b exp=0", bus.irq);
    end
    bus_read(4'h1, d);
    checks++;
    if (d !== 64'h1) begin
      errors++; $display("FAIL mr_status got=%016h exp=1", d);
    end
    bus_read(4'h3, d);
    checks++;
    if (d !== 64'h0) begin
      errors++; $display("FAIL mr_inten got=%016h exp=0", d);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset_n    = 1'b0;
    bus.s_sel  = 1'b0;
    bus.s_wr   = 1'b0;
    bus.s_addr = 16'd0;
    bus.s_din  = 64'd0;
    test_reset();
    test_push_pop();
    test_overflow();
    test_underflow();
    test_irq();
    test_wrap();
    test_unmapped();
    test_unselected();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_fifo_slave.md
Name: bus_fifo_slave

Overview:
- Memory-mapped 64-bit FIFO slave on the downstream side of the single-master bus; occupies one slave slot (s0 or s1) and is driven by that slot's sel, s_wr, s_addr and s_din.
- The master pushes 64-bit words by writing the DATA register and pops them by reading DATA.
- Status and control are exposed through word-offset registers.
- Read data is registered (1-cycle latency) to line up with the bus's registered read-mux select.

Parameters:
- DEPTH, 8, number of 64-bit FIFO entries; power of two, 2..128.
- AW, 3, pointer width = log2(DEPTH).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  synchronous active-low reset.
- s_sel  input  1  slave select from the bus address decoder.
- s_wr  input  1  1 = write, 0 = read; sampled only when s_sel=1.
- s_addr  input  16  bus address; only s_addr[3:0] is decoded (word offset).
- s_din  input  64  write data from the bus.
- s_dout  output  64  registered read data to the bus read mux.
- irq  output  1  level interrupt.

Behaviour:
- Reset: sampled on the clk rising edge while reset_n=0. All of the following go to 0: wr_ptr, rd_ptr, count, OVF, UNF, INT_EN, s_dout. Result: irq=0, empty=1, full=0. Memory contents are don't-care.
- Register map (s_addr[3:0]); any other offset reads 0 and ignores writes:
  - 0x0 DATA: write = push; read = pop.
  - 0x1 STATUS (RO):
    - bit0 empty, bit1 full, bit2 OVF (sticky), bit3 UNF (sticky).
    - bits[15:8] count, zero-extended.
    - all other bits 0.
  - 0x2 CTRL (WO, reads 0):
    - bit0=1 flushes the FIFO (pointers and count to 0).
    - bit1=1 clears OVF and UNF.
    - Both bits may be set in one write.
  - 0x3 INT_EN (RW): bit0 = not-empty interrupt enable, bit1 = error interrupt enable; other bits read 0.
- Access cycle: an access happens only when s_sel=1 at a clk edge. At most one access per cycle (single master), so a push and a pop never occur in the same cycle.
- Push (write DATA):
  - Not full: mem[wr_ptr] <= s_din, wr_ptr+1 (wraps modulo DEPTH), count+1.
  - Full: data dropped, pointers unchanged, OVF <= 1.
- Pop (read DATA):
  - Not empty: s_dout <= mem[rd_ptr] on that edge, rd_ptr+1 (wraps), count-1.
  - Empty: s_dout <= 0, UNF <= 1, pointers unchanged.
- Read latency: data from a read accepted at edge N is on s_dout after edge N and holds until edge N+1.
  - STATUS reads return the flag values from before that edge's update.
  - Every cycle with no read (idle, or any write) loads s_dout with 0.
- Flags:
  - empty = (count==0); full = (count==DEPTH).
  - count is AW+1 bits wide and never exceeds DEPTH.
- A CTRL flush takes effect on the edge it is written. A write to DATA on the following cycle is stored at entry 0.
- irq is registered: irq <= (INT_EN[0] & ~empty_next) | (INT_EN[1] & (OVF_next|UNF_next)), where _next is the value computed on the same edge.
- Reset mid-operation: the reset wins over any concurrent access. State returns to the reset values and the access is discarded.
- s_sel=0: s_wr, s_addr and s_din are ignored, including X values from the bus when the master is not granted. No state change is allowed from X on an unselected bus.

Test Plan:
- Reset, then read STATUS -> s_dout one cycle later = 0x0000_0000_0000_0001 (empty); irq=0.
- Push 0x1111..11, 0x2222..22, then pop twice -> s_dout = 0x1111..11, then 0x2222..22, each one cycle after its read; final STATUS = 0x1 (count 0).
- Push DEPTH+1 words (values 1..9 with DEPTH=8) -> STATUS = 0x0806 (count 8, full, OVF). Then 8 pops return 1..8 in order and the 9th word is absent.
- Pop on empty -> s_dout=0 and STATUS bit3 UNF=1. CTRL write 0x2 -> STATUS returns to 0x1.
- Set INT_EN=0x1 and push one word -> irq=1 on the following cycle. Pop -> irq=0 on the following cycle. Set INT_EN=0x2 and force OVF -> irq=1 until a CTRL bit1 write.
- Wrap check: push 6 and pop 6, then push 5 and pop 5 -> FIFO order preserved across pointer wrap. A mid-run reset_n=0 for one cycle -> STATUS=0x1 and irq=0 on the next read.
